uart_receiver: RTL and testbench

Serial-to-parallel UART receiver in the Riscv151 I/O path, directly upstream of the CPU's memory-mapped UART data/status registers. Samples FPGA_SERIAL_RX, recovers 8N1 frames, and holds each byte in a one-entry output register behind a ready/valid handshake. Reports framing errors and overruns as single-cycle pulses for the status register.

---
 rtl/uart_receiver.sv | 145 ++++++++++++++
 tb/tb_uart_receiver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// one-entry ready/valid output register with framing-error and overrun pulses.
module uart_receiver #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  logic [1:0]       sync_q;
  logic             rx_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_error_q;
  logic             overrun_q;
  logic             accept;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  // NOTE: sequential logic uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two sync stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serial_in};
    end
  end

  assign rx_s   = sync_q[1];
  assign accept = valid_q && data_out_ready;

  // NOTE: the pulse flags get a default clear at the top of the clocked block;
  // a later assignment in the same cycle wins, giving exact one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      if (accept) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rx_s) begin
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q == SAMPLE_LAST) begin
            cnt_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == SYMBOL_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == SYMBOL_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
              // A byte consumed at this very edge frees the slot for the new one.
              if (!valid_q || data_out_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        BREAK: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign frame_error    = frame_error_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: cycle-accurate frame driver plus a
// scoreboard of expected bytes/error pulses, each tagged with its due cycle.
module tb_uart_receiver;

  localparam int SYM         = 434;   // clocks per bit at 50 MHz / 115200
  localparam int STOP_SAMPLE = 4125;  // stop-bit sample edge relative to t0

  typedef enum logic [1:0] {EV_NONE, EV_BYTE, EV_FERR, EV_OVR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       data_out_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       frame_error;
  logic       overrun;

  int  n_checks = 0;
  int  n_err = 0;
  int  cyc = 0;
  ev_t sb_q[$];

  uart_receiver dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .frame_error    (frame_error),
    .overrun        (overrun)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_event(input ev_kind_e k);
    ev_t e;
    check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("ev_kind", 32'(k), 32'(e.kind));
      check("ev_cycle", 32'(cyc), 32'(e.cyc));
      if (k == EV_BYTE) begin
        check("ev_data", 32'(data_out), 32'(e.data));
      end
    end
  endtask

  // A new byte is visible when valid rises or reloads right after an accept.
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
    end else begin
      if (data_out_valid && (!prev_valid || prev_ready)) expect_event(EV_BYTE);
      if (frame_error) expect_event(EV_FERR);
      if (overrun) expect_event(EV_OVR);
      prev_valid <= data_out_valid;
      prev_ready <= data_out_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic consume();
    data_out_ready = 1'b1;
    step();
    data_out_ready = 1'b0;
    check("consume_valid", 32'(data_out_valid), 32'd0);
  endtask

  // Value set in iteration c is sampled by the DUT at edge t0+c.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rdy_at,
                            input int rst_at, input ev_kind_e ev);
    logic [9:0] frame;
    int         t0;
    frame = {stop_bit, b, 1'b0};
    t0    = cyc + 1;
    if (ev != EV_NONE) sb_q.push_back('{ev, b, t0 + STOP_SAMPLE});
    for (int c = 0; c < 10 * SYM; c++) begin
      serial_in = frame[c / SYM];
      if (rdy_at >= 0) data_out_ready = (c == rdy_at);
      rst = (c == rst_at);
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("rst_mid_data", 32'(data_out), 32'h00);
        check("rst_mid_valid", 32'(data_out_valid), 32'd0);
        check("rst_mid_ferr", 32'(frame_error), 32'd0);
        check("rst_mid_ovr", 32'(overrun), 32'd0);
      end
      step();
    end
    serial_in = 1'b1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] msg [5];
    msg = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h20};

    repeat (3) step();
    rst = 1'b0;
    idle(20);
    check("reset_data", 32'(data_out), 32'h00);
    check("reset_valid", 32'(data_out_valid), 32'd0);
    check("reset_ferr", 32'(frame_error), 32'd0);
    check("reset_ovr", 32'(overrun), 32'd0);

    // Basic reception with ready held low, then a single-cycle accept.
    send_frame(8'h61, 1'b1, -1, -1, EV_BYTE);
    check("t1_data", 32'(data_out), 32'h61);
    check("t1_valid", 32'(data_out_valid), 32'd1);
    consume();

    // Short low glitch must be rejected without any report.
    serial_in = 1'b0;
    repeat (100) step();
    idle(600);
    check("glitch_valid", 32'(data_out_valid), 32'd0);
    send_frame(8'h35, 1'b1, -1, -1, EV_BYTE);
    consume();

    // Stop bit low: frame error, byte dropped, recovery after line returns high.
    send_frame(8'hA5, 1'b0, -1, -1, EV_FERR);
    check("ferr_novalid", 32'(data_out_valid), 32'd0);
    idle(50);
    send_frame(8'h3E, 1'b1, -1, -1, EV_BYTE);
    consume();

    // Overrun: second byte arrives while the first is still unconsumed.
    send_frame(8'h31, 1'b1, -1, -1, EV_BYTE);
    send_frame(8'h0D, 1'b1, -1, -1, EV_OVR);
    check("ovr_hold_data", 32'(data_out), 32'h31);
    check("ovr_hold_valid", 32'(data_out_valid), 32'd1);
    consume();

    // Accept exactly at the completing edge: no overrun, new byte loads.
    send_frame(8'h31, 1'b1, -1, -1, EV_BYTE);
    send_frame(8'h0D, 1'b1, STOP_SAMPLE, -1, EV_BYTE);
    check("edge_accept_data", 32'(data_out), 32'h0D);
    check("edge_accept_valid", 32'(data_out_valid), 32'd1);
    consume();

    // Back-to-back frames with ready tied high.
    data_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_frame(msg[i], 1'b1, -1, -1, EV_BYTE);
    step();
    data_out_ready = 1'b0;
    check("b2b_drained", 32'(data_out_valid), 32'd0);

    // Reset during data bit 4 clears a pending byte and aborts the frame.
    send_frame(8'h55, 1'b1, -1, -1, EV_BYTE);
    check("pre_rst_valid", 32'(data_out_valid), 32'd1);
    send_frame(8'hF5, 1'b1, -1, 2300, EV_NONE);
    idle(100);
    check("post_rst_valid", 32'(data_out_valid), 32'd0);
    send_frame(8'h0A, 1'b1, -1, -1, EV_BYTE);
    check("after_rst_data", 32'(data_out), 32'h0A);
    consume();

    idle(20);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
